ser_rx: RTL and testbench

- Serial-to-parallel receiver; the receive end of the LSB-first serial link driven by the team's parallel-load shift register.
- Detects a start bit on an idle-high line, samples W data bits at mid-bit, checks the stop bit, and presents the word on a valid/ready output.
- Sits between an asynchronous serial pin and a synchronous consumer.

---
 rtl/ser_pkg.sv | 22 ++
 rtl/sync2.sv | 24 ++
 rtl/ser_rx.sv | 178 +++++++++++++++++
 tb/tb_ser_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and helpers for the serial receive path.
package ser_pkg;

  // Receiver FSM states; PARITY is only entered when the parity build option is enabled.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI,
    PARITY
  } rx_state_t;

  // Smallest bit period that still leaves a usable mid-bit sample point.
  localparam int MIN_CLKS_PER_BIT = 4;

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ser_rx.sv
// Serial-to-parallel receiver: LSB-first frames (start, W data, [parity], stop)
// on an idle-high line, presented on a valid/ready output.
// Build option SER_RX_PARITY_EN adds an even-parity bit and the perr output.
module ser_rx
  import ser_pkg::*;
#(
  parameter int W            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rxd,
  input  logic         rdy,
  output logic [W-1:0] q,
  output logic         valid,
  output logic         ferr,
`ifdef SER_RX_PARITY_EN
  output logic         perr,
`endif
  output logic         ovr
);

  localparam int TW = cnt_width(CLKS_PER_BIT - 1);
  localparam int BW = cnt_width(W);

  // Tick counter is loaded with N-1 and expires when it reaches zero, giving N cycles.
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(W - 1);

  rx_state_t     state;
  logic [TW-1:0] tick;
  logic [BW-1:0] bit_cnt;
  logic [W-1:0]  sh;
  logic [W-1:0]  sh_next;
  logic          rxd_s;
  logic          tick_done;
  logic          par_bad;
`ifdef SER_RX_PARITY_EN
  logic          par_bit;
`endif

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  assign tick_done = (tick == '0);

  // New bits enter at the MSB so the first bit received ends up in q[0].
  generate
    if (W == 1) begin : g_sh1
      assign sh_next = rxd_s;
    end else begin : g_shn
      assign sh_next = {rxd_s, sh[W-1:1]};
    end
  endgenerate

`ifdef SER_RX_PARITY_EN
  assign par_bad = ^{sh, par_bit};
`else
  assign par_bad = 1'b0;
`endif

  // Frame FSM plus registered outputs and the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      q       <= '0;
      valid   <= 1'b0;
      ferr    <= 1'b0;
      ovr     <= 1'b0;
`ifdef SER_RX_PARITY_EN
      perr    <= 1'b0;
      par_bit <= 1'b0;
`endif
    end else begin
      ferr <= 1'b0;
      ovr  <= 1'b0;
`ifdef SER_RX_PARITY_EN
      perr <= 1'b0;
`endif
      // Consumer accept; a capture later in this block overrides the clear.
      if (valid && rdy) begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            tick  <= TICK_HALF;
          end
        end

        START: begin
          if (tick_done) begin
            if (!rxd_s) begin
              state   <= DATA;
              tick    <= TICK_FULL;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            tick <= tick - TW'(1);
          end
        end

        DATA: begin
          if (tick_done) begin
            sh      <= sh_next;
            bit_cnt <= bit_cnt + BW'(1);
            tick    <= TICK_FULL;
            if (bit_cnt == LAST_BIT) begin
`ifdef SER_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            tick <= tick - TW'(1);
          end
        end

`ifdef SER_RX_PARITY_EN
        PARITY: begin
          if (tick_done) begin
            par_bit <= rxd_s;
            tick    <= TICK_FULL;
            state   <= STOP;
          end else begin
            tick <= tick - TW'(1);
          end
        end
`endif

        STOP: begin
          if (tick_done) begin
`ifdef SER_RX_PARITY_EN
            perr <= par_bad;
`endif
            if (rxd_s) begin
              if (!par_bad) begin
                q     <= sh;
                valid <= 1'b1;
                ovr   <= valid && !rdy;
              end
              state <= IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= WAIT_HI;
            end
          end else begin
            tick <= tick - TW'(1);
          end
        end

        WAIT_HI: begin
          if (rxd_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_rx.sv
// Directed testbench for ser_rx (W=8, CLKS_PER_BIT=16).
// Compile with SER_RX_PARITY_EN defined to also exercise the parity option.
module tb_ser_rx;

  localparam int W   = 8;
  localparam int CPB = 16;
`ifdef SER_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  // rxd fall at a negedge -> 2 sync flops + 1 cycle IDLE detect + half bit
  // + W data bits + [parity] + stop-bit sample; valid seen at the following negedge.
  localparam int EXP_LAT = 3 + CPB / 2 + (W + NPAR + 1) * CPB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rxd;
  logic         rdy;
  logic [W-1:0] q;
  logic         valid;
  logic         ferr;
  logic         ovr;
`ifdef SER_RX_PARITY_EN
  logic         perr;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // Monitor state (written only by the monitor processes)
  int           cyc = 0;
  int           n_valid = 0;
  int           n_ferr = 0;
  int           n_ovr = 0;
  int           n_perr = 0;
  int           rise_cyc = 0;
  int           start_cyc = 0;
  logic [W-1:0] q_cap = '0;
  logic         valid_d = 1'b0;

  always #5 clk = ~clk;

  ser_rx #(.W(W), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .rdy   (rdy),
    .q     (q),
    .valid (valid),
    .ferr  (ferr),
`ifdef SER_RX_PARITY_EN
    .perr  (perr),
`endif
    .ovr   (ovr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_valid = n_valid + 1;
      q_cap   = q;
    end
    if (valid && !valid_d) rise_cyc = cyc;
    valid_d = valid;
    if (ferr) n_ferr = n_ferr + 1;
    if (ovr)  n_ovr  = n_ovr + 1;
`ifdef SER_RX_PARITY_EN
    if (perr) n_perr = n_perr + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic hold(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  // One frame, LSB first; stop_b sets the stop level, par_flip corrupts parity.
  task automatic send(input logic [W-1:0] d, input logic stop_b, input logic par_flip);
    @(negedge clk);
    start_cyc = cyc;
    hold(1'b0);
    for (int i = 0; i < W; i++) hold(d[i]);
`ifdef SER_RX_PARITY_EN
    hold((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity option");
`endif
    hold(stop_b);
  endtask

  task automatic idle(input int bits);
    rxd = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  int b_valid, b_ferr, b_ovr, b_perr;

  task automatic snap();
    b_valid = n_valid;
    b_ferr  = n_ferr;
    b_ovr   = n_ovr;
    b_perr  = n_perr;
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    rdy   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_ferr", 32'(ferr), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Clean frame
    snap();
    send(8'hA5, 1'b1, 1'b0);
    idle(1);
    chk("clean_q", 32'(q_cap), 32'hA5);
    chk("clean_valid_cycles", 32'(n_valid - b_valid), 32'd1);
    chk("clean_ferr", 32'(n_ferr - b_ferr), 32'd0);
    chk("clean_ovr", 32'(n_ovr - b_ovr), 32'd0);
    chk("clean_latency", 32'(rise_cyc - start_cyc), 32'(EXP_LAT));

    // Glitch on the line, then a real frame
    snap();
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(2);
    chk("glitch_valid", 32'(n_valid - b_valid), 32'd0);
    chk("glitch_ferr", 32'(n_ferr - b_ferr), 32'd0);
    send(8'h3C, 1'b1, 1'b0);
    idle(1);
    chk("after_glitch_q", 32'(q_cap), 32'h3C);
    chk("after_glitch_valid", 32'(n_valid - b_valid), 32'd1);

    // Framing error followed by a long break
    snap();
    send(8'h55, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    idle(2);
    chk("ferr_pulses", 32'(n_ferr - b_ferr), 32'd1);
    chk("ferr_valid", 32'(n_valid - b_valid), 32'd0);
    send(8'h0F, 1'b1, 1'b0);
    idle(1);
    chk("after_ferr_q", 32'(q_cap), 32'h0F);
    chk("after_ferr_ferr", 32'(n_ferr - b_ferr), 32'd1);

    // Back-pressure and overrun
    snap();
    rdy = 1'b0;
    send(8'h11, 1'b1, 1'b0);
    idle(1);
    chk("bp_valid1", 32'(valid), 32'h1);
    chk("bp_q1", 32'(q), 32'h11);
    chk("bp_ovr1", 32'(n_ovr - b_ovr), 32'd0);
    send(8'h22, 1'b1, 1'b0);
    idle(1);
    chk("bp_ovr2", 32'(n_ovr - b_ovr), 32'd1);
    chk("bp_q2", 32'(q), 32'h22);
    chk("bp_valid2", 32'(valid), 32'h1);
    rdy = 1'b1;
    @(negedge clk);
    chk("bp_accept", 32'(valid), 32'h0);

    // Reset in the middle of data bit 3 of 8'hFF
    snap();
    @(negedge clk);
    hold(1'b0);
    hold(1'b1);
    hold(1'b1);
    hold(1'b1);
    repeat (CPB / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("midrst_no_partial", 32'(n_valid - b_valid), 32'd0);
    send(8'h81, 1'b1, 1'b0);
    idle(1);
    chk("after_rst_q", 32'(q_cap), 32'h81);

`ifdef SER_RX_PARITY_EN
    // Parity error, then a correct parity frame
    snap();
    send(8'h07, 1'b1, 1'b1);
    idle(1);
    chk("perr_pulses", 32'(n_perr - b_perr), 32'd1);
    chk("perr_valid", 32'(n_valid - b_valid), 32'd0);
    send(8'h07, 1'b1, 1'b0);
    idle(1);
    chk("par_ok_q", 32'(q_cap), 32'h07);
    chk("par_ok_valid", 32'(n_valid - b_valid), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
